// File: rtl/texture_fetch_arbiter_if.sv
// Request/acknowledge, texture ROM and response signals shared between the
// sprite renderers, the texture ROM and the fetch arbiter.
interface texture_fetch_arbiter_if;
    logic        rex_req;
    logic [4:0]  rex_col;
    logic        rex_ack;
    logic        obs_req;
    logic [4:0]  obs_col;
    logic        obs_ack;
    logic [9:0]  rom_addr;
    logic [7:0]  rom_data;
    logic        rsp_valid;
    logic        rsp_owner;
    logic [23:0] rsp_data;
    logic        rsp_err;

    modport slave (
        input  rex_req, rex_col, obs_req, obs_col, rom_data,
        output rex_ack, obs_ack, rom_addr, rsp_valid, rsp_owner, rsp_data, rsp_err
    );

    modport master (
        output rex_req, rex_col, obs_req, obs_col, rom_data,
        input  rex_ack, obs_ack, rom_addr, rsp_valid, rsp_owner, rsp_data, rsp_err
    );
endinterface

// File: rtl/texture_fetch_arbiter.sv
// Round-robin arbiter that shares one combinational texture ROM between the
// t-rex and obstacle renderers and assembles a vertical sprite column per request.
module texture_fetch_arbiter #(
    parameter int REX_BASE  = 0,
    parameter int REX_COLS  = 23,
    parameter int REX_PAGES = 3,
    parameter int OBS_BASE  = 69,
    parameter int OBS_COLS  = 22,
    parameter int OBS_PAGES = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    texture_fetch_arbiter_if.slave  bus
);
    localparam logic [9:0] REX_BASE_W = 10'(REX_BASE);
    localparam logic [9:0] REX_COLS_W = 10'(REX_COLS);
    localparam logic [1:0] REX_LAST_W = 2'(REX_PAGES - 1);
    localparam logic [9:0] OBS_BASE_W = 10'(OBS_BASE);
    localparam logic [9:0] OBS_COLS_W = 10'(OBS_COLS);
    localparam logic [1:0] OBS_LAST_W = 2'(OBS_PAGES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state_r, state_s;
    logic        owner_r;
    logic [4:0]  col_r;
    logic [1:0]  page_r;
    logic [23:0] data_r;
    logic        ptr_r;          // 1: obstacle wins the next tie
    logic        rsp_owner_r;
    logic [23:0] rsp_data_r;
    logic        rsp_err_r;

    logic        grant_rex_s;
    logic        grant_obs_s;
    logic [4:0]  col_sel_s;
    logic        range_err_s;
    logic [9:0]  rom_addr_s;
    logic        rsp_valid_s;
    logic [1:0]  last_page_s;
    logic [23:0] data_next_s;

    // Page-major layout: each page is a full row of columns, truncated to 10 bits.
    function automatic logic [9:0] fetch_addr(input logic owner, input logic [1:0] page,
                                              input logic [4:0] col);
        logic [9:0] base_v;
        logic [9:0] cols_v;
        base_v = owner ? OBS_BASE_W : REX_BASE_W;
        cols_v = owner ? OBS_COLS_W : REX_COLS_W;
        return base_v + ({8'd0, page} * cols_v) + {5'd0, col};
    endfunction

    // Arbitration, next-state decode and byte-lane merge of the current ROM read.
    always_comb begin
        state_s     = state_r;
        grant_rex_s = 1'b0;
        grant_obs_s = 1'b0;
        col_sel_s   = bus.rex_col;
        range_err_s = 1'b0;
        rom_addr_s  = 10'd0;
        rsp_valid_s = 1'b0;
        last_page_s = owner_r ? OBS_LAST_W : REX_LAST_W;
        data_next_s = data_r;
        case (page_r)
            2'd0:    data_next_s[7:0]   = bus.rom_data;
            2'd1:    data_next_s[15:8]  = bus.rom_data;
            2'd2:    data_next_s[23:16] = bus.rom_data;
            default: data_next_s        = data_r;
        endcase
        case (state_r)
            IDLE: begin
                if (rst) begin
                    grant_rex_s = 1'b0;
                end else if (bus.rex_req && (!bus.obs_req || !ptr_r)) begin
                    grant_rex_s = 1'b1;
                end else if (bus.obs_req) begin
                    grant_obs_s = 1'b1;
                end else begin
                    grant_obs_s = 1'b0;
                end
                if (grant_obs_s) begin
                    col_sel_s = bus.obs_col;
                end else begin
                    col_sel_s = bus.rex_col;
                end
                range_err_s = ({5'd0, col_sel_s} >= (grant_obs_s ? OBS_COLS_W : REX_COLS_W));
                if (grant_rex_s || grant_obs_s) begin
                    state_s = range_err_s ? DONE : FETCH;
                end else begin
                    state_s = IDLE;
                end
            end
            FETCH: begin
                rom_addr_s = fetch_addr(owner_r, page_r, col_r);
                if (page_r == last_page_s) begin
                    state_s = DONE;
                end else begin
                    state_s = FETCH;
                end
            end
            DONE: begin
                rsp_valid_s = 1'b1;
                state_s     = IDLE;
            end
            default: state_s = IDLE;
        endcase
    end

    // Transaction context, page counter, assembly register and held response.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            owner_r     <= 1'b0;
            col_r       <= 5'd0;
            page_r      <= 2'd0;
            data_r      <= 24'd0;
            ptr_r       <= 1'b0;
            rsp_owner_r <= 1'b0;
            rsp_data_r  <= 24'd0;
            rsp_err_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            if (grant_rex_s || grant_obs_s) begin
                owner_r <= grant_obs_s;
                col_r   <= col_sel_s;
                page_r  <= 2'd0;
                data_r  <= 24'd0;
                ptr_r   <= grant_rex_s;
                if (range_err_s) begin
                    rsp_owner_r <= grant_obs_s;
                    rsp_data_r  <= 24'd0;
                    rsp_err_r   <= 1'b1;
                end
            end else if (state_r == FETCH) begin
                data_r <= data_next_s;
                page_r <= page_r + 2'd1;
                if (page_r == last_page_s) begin
                    rsp_owner_r <= owner_r;
                    rsp_data_r  <= data_next_s;
                    rsp_err_r   <= 1'b0;
                end
            end
        end
    end

    assign bus.rex_ack   = grant_rex_s;
    assign bus.obs_ack   = grant_obs_s;
    assign bus.rom_addr  = rom_addr_s;
    assign bus.rsp_valid = rsp_valid_s;
    assign bus.rsp_owner = rsp_owner_r;
    assign bus.rsp_data  = rsp_data_r;
    assign bus.rsp_err   = rsp_err_r;
endmodule

// File: tb/tb_texture_fetch_arbiter.sv
// Bench for texture_fetch_arbiter: directed vector table, a reset-abort sequence
// and a random phase checked against a transaction-timeline reference model.
module tb_texture_fetch_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    texture_fetch_arbiter_if bus ();

    texture_fetch_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [7:0] rom_mem [1024];
    assign bus.rom_data = rom_mem[bus.rom_addr];

    typedef struct {
        bit          rst;
        bit          rr;
        logic [4:0]  rc;
        bit          orq;
        logic [4:0]  oc;
        logic [38:0] exp;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [7:0] rom_val(input int a);
        case (a)
            0:       return 8'h01;
            23:      return 8'h0C;
            46:      return 8'h60;
            69:      return 8'h03;
            90:      return 8'hBC;
            91:      return 8'hBC;
            112:     return 8'h00;
            default: return 8'((a * 7 + 3) % 256);
        endcase
    endfunction

    function automatic logic [38:0] pk(input bit ra, input bit oa, input logic [9:0] addr,
                                       input bit v, input bit own, input bit err,
                                       input logic [23:0] d);
        return {ra, oa, addr, v, own, err, d};
    endfunction

    function automatic logic [38:0] outs();
        return {bus.rex_ack, bus.obs_ack, bus.rom_addr, bus.rsp_valid,
                bus.rsp_owner, bus.rsp_err, bus.rsp_data};
    endfunction

    function automatic vec_t mk(input bit r, input bit rr, input logic [4:0] rc,
                                input bit orq, input logic [4:0] oc, input logic [38:0] e);
        vec_t v;
        v.rst = r; v.rr = rr; v.rc = rc; v.orq = orq; v.oc = oc; v.exp = e;
        return v;
    endfunction

    task automatic check(input string name, input logic [38:0] act, input logic [38:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (rex_ack,obs_ack,addr,valid,owner,err,data)",
                     name, act, exp);
        end
    endtask

    // Inputs change just after the rising edge; outputs are sampled on the falling edge.
    task automatic cycle(input bit r, input bit rr, input logic [4:0] rc,
                         input bit orq, input logic [4:0] oc);
        @(posedge clk);
        #1;
        rst = r; bus.rex_req = rr; bus.rex_col = rc; bus.obs_req = orq; bus.obs_col = oc;
        @(negedge clk);
    endtask

    logic [23:0] r1, o2;
    logic [9:0]  e_addr  [512];
    bit          e_valid [512];
    bit          e_owner [512];
    bit          e_err   [512];
    logic [23:0] e_data  [512];

    initial begin
        for (int a = 0; a < 1024; a++) rom_mem[a] = rom_val(a);
        bus.rex_req = 1'b0; bus.rex_col = 5'd0; bus.obs_req = 1'b0; bus.obs_col = 5'd0;

        r1 = {rom_val(47), rom_val(24), rom_val(1)};
        o2 = {8'h00, rom_val(93), rom_val(71)};

        tbl.push_back(mk(0, 1, 5'd0,  0, 5'd0,  pk(1, 0, 10'd0,   0, 0, 0, 24'h0)));
        tbl.push_back(mk(0, 0, 5'd0,  0, 5'd0,  pk(0, 0, 10'd0,   0, 0, 0, 24'h0)));
        tbl.push_back(mk(0, 0, 5'd0,  0, 5'd0,  pk(0, 0, 10'd23,  0, 0, 0, 24'h0)));
        tbl.push_back(mk(0, 0, 5'd0,  0, 5'd0,  pk(0, 0, 10'd46,  0, 0, 0, 24'h0)));
        tbl.push_back(mk(0, 0, 5'd0,  0, 5'd0,  pk(0, 0, 10'd0,   1, 0, 0, 24'h600C01)));
        tbl.push_back(mk(0, 0, 5'd0,  1, 5'd0,  pk(0, 1, 10'd0,   0, 0, 0, 24'h600C01)));
        tbl.push_back(mk(0, 0, 5'd0,  0, 5'd0,  pk(0, 0, 10'd69,  0, 0, 0, 24'h600C01)));
        tbl.push_back(mk(0, 0, 5'd0,  0, 5'd0,  pk(0, 0, 10'd91,  0, 0, 0, 24'h600C01)));
        tbl.push_back(mk(0, 0, 5'd0,  0, 5'd0,  pk(0, 0, 10'd0,   1, 1, 0, 24'h00BC03)));
        tbl.push_back(mk(0, 0, 5'd0,  1, 5'd21, pk(0, 1, 10'd0,   0, 1, 0, 24'h00BC03)));
        tbl.push_back(mk(0, 0, 5'd0,  0, 5'd0,  pk(0, 0, 10'd90,  0, 1, 0, 24'h00BC03)));
        tbl.push_back(mk(0, 0, 5'd0,  0, 5'd0,  pk(0, 0, 10'd112, 0, 1, 0, 24'h00BC03)));
        tbl.push_back(mk(0, 0, 5'd0,  0, 5'd0,  pk(0, 0, 10'd0,   1, 1, 0, 24'h0000BC)));
        tbl.push_back(mk(0, 1, 5'd23, 0, 5'd0,  pk(1, 0, 10'd0,   0, 1, 0, 24'h0000BC)));
        tbl.push_back(mk(0, 0, 5'd0,  0, 5'd0,  pk(0, 0, 10'd0,   1, 0, 1, 24'h0)));
        tbl.push_back(mk(0, 0, 5'd0,  0, 5'd0,  pk(0, 0, 10'd0,   0, 0, 1, 24'h0)));
        tbl.push_back(mk(1, 0, 5'd0,  0, 5'd0,  pk(0, 0, 10'd0,   0, 0, 1, 24'h0)));
        // Both requesters held high from reset release: rex, obs, rex, obs.
        tbl.push_back(mk(0, 1, 5'd1,  1, 5'd2,  pk(1, 0, 10'd0,   0, 0, 0, 24'h0)));
        tbl.push_back(mk(0, 1, 5'd1,  1, 5'd2,  pk(0, 0, 10'd1,   0, 0, 0, 24'h0)));
        tbl.push_back(mk(0, 1, 5'd1,  1, 5'd2,  pk(0, 0, 10'd24,  0, 0, 0, 24'h0)));
        tbl.push_back(mk(0, 1, 5'd1,  1, 5'd2,  pk(0, 0, 10'd47,  0, 0, 0, 24'h0)));
        tbl.push_back(mk(0, 1, 5'd1,  1, 5'd2,  pk(0, 0, 10'd0,   1, 0, 0, r1)));
        tbl.push_back(mk(0, 1, 5'd1,  1, 5'd2,  pk(0, 1, 10'd0,   0, 0, 0, r1)));
        tbl.push_back(mk(0, 1, 5'd1,  1, 5'd2,  pk(0, 0, 10'd71,  0, 0, 0, r1)));
        tbl.push_back(mk(0, 1, 5'd1,  1, 5'd2,  pk(0, 0, 10'd93,  0, 0, 0, r1)));
        tbl.push_back(mk(0, 1, 5'd1,  1, 5'd2,  pk(0, 0, 10'd0,   1, 1, 0, o2)));
        tbl.push_back(mk(0, 1, 5'd1,  1, 5'd2,  pk(1, 0, 10'd0,   0, 1, 0, o2)));
        tbl.push_back(mk(0, 1, 5'd1,  1, 5'd2,  pk(0, 0, 10'd1,   0, 1, 0, o2)));
        tbl.push_back(mk(0, 1, 5'd1,  1, 5'd2,  pk(0, 0, 10'd24,  0, 1, 0, o2)));
        tbl.push_back(mk(0, 1, 5'd1,  1, 5'd2,  pk(0, 0, 10'd47,  0, 1, 0, o2)));
        tbl.push_back(mk(0, 1, 5'd1,  1, 5'd2,  pk(0, 0, 10'd0,   1, 0, 0, r1)));
        tbl.push_back(mk(0, 1, 5'd1,  1, 5'd2,  pk(0, 1, 10'd0,   0, 0, 0, r1)));
        tbl.push_back(mk(0, 1, 5'd1,  1, 5'd2,  pk(0, 0, 10'd71,  0, 0, 0, r1)));
        tbl.push_back(mk(0, 1, 5'd1,  1, 5'd2,  pk(0, 0, 10'd93,  0, 0, 0, r1)));
        tbl.push_back(mk(0, 1, 5'd1,  1, 5'd2,  pk(0, 0, 10'd0,   1, 1, 0, o2)));
        tbl.push_back(mk(0, 0, 5'd0,  0, 5'd0,  pk(0, 0, 10'd0,   0, 1, 0, o2)));

        // Reset state.
        cycle(1, 0, 5'd0, 0, 5'd0);
        cycle(1, 0, 5'd0, 0, 5'd0);
        check("reset", outs(), pk(0, 0, 10'd0, 0, 0, 0, 24'h0));

        foreach (tbl[i]) begin
            cycle(tbl[i].rst, tbl[i].rr, tbl[i].rc, tbl[i].orq, tbl[i].oc);
            check($sformatf("vec%0d", i), outs(), tbl[i].exp);
        end

        // Reset during the second FETCH of a t-rex request aborts it.
        cycle(0, 1, 5'd5, 0, 5'd0);
        check("abort_ack", outs(), pk(1, 0, 10'd0, 0, 1, 0, o2));
        cycle(0, 0, 5'd0, 0, 5'd0);
        check("abort_p0", outs(), pk(0, 0, 10'd5, 0, 1, 0, o2));
        cycle(1, 0, 5'd0, 0, 5'd0);
        check("abort_p1", outs(), pk(0, 0, 10'd28, 0, 1, 0, o2));
        for (int k = 0; k < 5; k++) begin
            cycle(0, 0, 5'd0, 0, 5'd0);
            check($sformatf("abort_quiet%0d", k), outs(), pk(0, 0, 10'd0, 0, 0, 0, 24'h0));
        end
        cycle(0, 1, 5'd3, 1, 5'd4);
        check("abort_regrant", outs(), pk(1, 0, 10'd0, 0, 0, 0, 24'h0));

        // Random phase against a timeline model.
        cycle(1, 0, 5'd0, 0, 5'd0);
        for (int i = 0; i < 512; i++) begin
            e_addr[i] = 10'd0; e_valid[i] = 1'b0; e_owner[i] = 1'b0;
            e_err[i] = 1'b0; e_data[i] = 24'h0;
        end
        begin
            bit          rex_pend, obs_pend, favor_obs, ga_r, ga_o;
            bit          h_owner, h_err, own;
            logic [23:0] h_data, d;
            logic [4:0]  rcol, ocol, col;
            logic [9:0]  a;
            int          free_at, base, cols, pages;
            rex_pend = 1'b0; obs_pend = 1'b0; favor_obs = 1'b0; free_at = 0;
            h_owner = 1'b0; h_err = 1'b0; h_data = 24'h0;
            for (int n = 0; n < 400; n++) begin
                if (!rex_pend) rex_pend = ($urandom_range(0, 2) == 0);
                if (!obs_pend) obs_pend = ($urandom_range(0, 2) == 0);
                rcol = 5'($urandom_range(0, 31));
                ocol = 5'($urandom_range(0, 31));
                ga_r = 1'b0; ga_o = 1'b0;
                if (n >= free_at && (rex_pend || obs_pend)) begin
                    if (rex_pend && (!obs_pend || !favor_obs)) ga_r = 1'b1;
                    else ga_o = 1'b1;
                    favor_obs = ga_r;
                    own   = ga_o;
                    base  = ga_o ? 69 : 0;
                    cols  = ga_o ? 22 : 23;
                    pages = ga_o ? 2 : 3;
                    col   = ga_o ? ocol : rcol;
                    if (int'(col) >= cols) begin
                        e_valid[n + 1] = 1'b1; e_owner[n + 1] = own;
                        e_err[n + 1] = 1'b1;   e_data[n + 1] = 24'h0;
                        free_at = n + 2;
                    end else begin
                        d = 24'h0;
                        for (int p = 0; p < pages; p++) begin
                            a = 10'((base + p * cols + int'(col)) % 1024);
                            e_addr[n + 1 + p] = a;
                            d[8 * p +: 8] = rom_mem[a];
                        end
                        e_valid[n + 1 + pages] = 1'b1; e_owner[n + 1 + pages] = own;
                        e_err[n + 1 + pages] = 1'b0;   e_data[n + 1 + pages] = d;
                        free_at = n + pages + 2;
                    end
                end
                cycle(0, rex_pend, rcol, obs_pend, ocol);
                if (e_valid[n]) begin
                    h_owner = e_owner[n]; h_err = e_err[n]; h_data = e_data[n];
                end
                check($sformatf("rnd%0d", n), outs(),
                      pk(ga_r, ga_o, e_addr[n], e_valid[n], h_owner, h_err, h_data));
                if (ga_r) rex_pend = 1'b0;
                if (ga_o) obs_pend = 1'b0;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/texture_fetch_arbiter.md
# texture_fetch_arbiter

Shares the single combinational texture ROM (10-bit address, 8-bit data) between the two sprite renderers: the t-rex and the obstacle. Each renderer requests one sprite column. The block arbitrates between them round-robin, sequences one ROM read per page byte, and returns the assembled vertical pixel column with a one-cycle valid strobe. Sprite data in the ROM is page-major, one byte per 8-pixel column slice, with bit 0 at the top pixel.

## Interface

- REX_BASE, 0: ROM address of t-rex page 0, column 0
- REX_COLS, 23: t-rex width in columns
- REX_PAGES, 3: t-rex height in 8-pixel pages
- OBS_BASE, 69: ROM address of obstacle page 0, column 0
- OBS_COLS, 22: obstacle width in columns
- OBS_PAGES, 2: obstacle height in pages (each PAGES ≤ 3; BASE+PAGES*COLS ≤ 1024)

Ports:

- clk  in  1  single clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- rex_req  in  1  t-rex column request, held until rex_ack
- rex_col  in  5  requested t-rex column; sampled on the rex_ack edge
- rex_ack  out  1  one-cycle accept pulse
- obs_req  in  1  obstacle column request, held until obs_ack
- obs_col  in  5  requested obstacle column; sampled on the obs_ack edge
- obs_ack  out  1  one-cycle accept pulse
- rom_addr  out  10  texture ROM address
- rom_data  in  8  texture ROM data, combinational from rom_addr
- rsp_valid  out  1  one-cycle response strobe
- rsp_owner  out  1  0 = t-rex, 1 = obstacle
- rsp_data  out  24  column pixels; page p occupies bits [8p+7:8p]; unused pages are 0
- rsp_err  out  1  requested column was out of range

## Operation

- FSM states:
  - IDLE: rom_addr = 0. With any req high, grant one requester:
    - Only one requester high: grant it.
    - Both high: grant the requester not served last. The pointer resets to favour t-rex.
    - Grant actions: assert that port's ack combinationally in this cycle, latch owner and col, clear the page counter and data register, and toggle the pointer to the other requester.
    - If col ≥ COLS of the owner, go to DONE with err = 1. Otherwise go to FETCH.
  - FETCH (one cycle per page):
    - rom_addr = BASE + page*COLS + col. Arithmetic is unsigned and truncated to 10 bits.
    - On the edge, rom_data is written into byte lane `page` and the counter increments.
    - After page = PAGES−1, go to DONE.
  - DONE: rsp_valid = 1 for one cycle, rom_addr = 0, then return to IDLE. No grant occurs in DONE.
- rsp_owner, rsp_data and rsp_err are registered. They update at entry to DONE and hold until the next DONE.
- A req still high after its ack is treated as a new request. Column inputs are ignored outside the ack cycle.
- An out-of-range request performs no ROM reads and returns rsp_data = 0.

## Timing

- Reset values: all outputs 0, state IDLE, pointer = t-rex.
- rst during FETCH or DONE aborts the transaction. No rsp_valid is issued for it.
- Define the accept edge as T, the edge that ends the ack cycle.
  - rom_addr carries page p during cycle T+1+p.
  - rsp_valid is high in cycle T+PAGES+1: t-rex 4 cycles after ack, obstacle 3.
  - For an error response, rsp_valid is high in cycle T+1.
- Next possible ack is the cycle after DONE. Peak throughput is one t-rex column per 5 cycles or one obstacle column per 4 cycles.
- With both requesters continuously high, grants strictly alternate and the first grant goes to t-rex.
- ack never asserts with its req low. At most one ack is high per cycle.

## Test plan

- Reset, then rex_req with rex_col=0:
  - rex_ack is high for 1 cycle.
  - rom_addr sequence is 0, 23, 46.
  - rsp_valid arrives 4 cycles after ack with rsp_data=24'h600C01, owner 0, err 0.
- obs_req with obs_col=0:
  - rom_addr sequence is 69, 91.
  - Response is rsp_data=24'h00BC03 with owner 1.
- obs_col=21:
  - rom_addr sequence is 90, 112.
  - Response is 24'h0000BC, since address 112 reads 0x00.
- Both reqs held high from reset release for 4 transactions:
  - Grant order is rex, obs, rex, obs.
  - Ack pulses are 5/4 cycles apart as specified.
  - No overlapping acks.
- rex_col=23:
  - rsp_valid occurs 1 cycle after ack with data 0 and err 1.
  - rom_addr stays 0 throughout.
- rst asserted during the second FETCH cycle of a t-rex request:
  - No rsp_valid follows.
  - Outputs are 0 after the reset edge.
  - A following simultaneous request grants t-rex first.
